// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: width helpers, state encoding and default sample width.
// Used by the multiplier, the product accumulator and downstream scaling stages.
package dsp_pkg;

  localparam int OUT_W_DEF = 8;
  localparam int PROD_W    = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Enough headroom for TAPS full-scale products, so the sum can never wrap.
  function automatic int acc_width(input int taps);
    return PROD_W + clog2(taps);
  endfunction

endpackage

// File: rtl/round_saturate.sv
// Round-half-up arithmetic right shift followed by saturation to OUT_W signed bits.
// Purely combinational; no handshake.
module round_saturate #(
  parameter int IN_W  = 19,
  parameter int SHIFT = 7,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(1 << (OUT_W - 1)));

  logic signed [IN_W:0] w_ext;
  logic signed [IN_W:0] w_r;

  // One extra bit so the rounding add cannot wrap at the positive extreme.
  assign w_ext = {x[IN_W-1], x} + RND;
  assign w_r   = w_ext >>> SHIFT;

  always_comb begin
    y   = w_r[OUT_W-1:0];
    sat = 1'b0;
    if (w_r > MAXV) begin
      y   = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (w_r < MINV) begin
      y   = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums frames of TAPS signed products; result valid one cycle after the last product.
// Valid-only input, always accepted (no backpressure); i_clear aborts the current frame.
module product_accumulator
  import dsp_pkg::*;
#(
  parameter int TAPS  = 8,
  parameter int SHIFT = 7,
  parameter int OUT_W = OUT_W_DEF,
  parameter int ACC_W = acc_width(TAPS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_valid,
  input  logic signed [15:0]      i_product,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic signed [ACC_W-1:0] o_sum,
  output logic signed [OUT_W-1:0] o_sample,
  output logic                    o_sat
);

  localparam int CNT_W = clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

  acc_state_t              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_valid;
  logic signed [ACC_W-1:0] r_sum;
  logic signed [OUT_W-1:0] r_sample;
  logic                    r_sat;

  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_final;
  logic signed [OUT_W-1:0] w_sample;
  logic                    w_sat;

  assign w_prod_ext = {{(ACC_W-16){i_product[15]}}, i_product};
  assign w_final    = r_acc + w_prod_ext;

  round_saturate #(
    .IN_W  (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_saturate (
    .x   (w_final),
    .y   (w_sample),
    .sat (w_sat)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_valid  <= 1'b0;
      r_sum    <= '0;
      r_sample <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (i_valid) begin
        case (r_state)
          ST_IDLE: begin
            r_acc   <= w_prod_ext;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_ACCUM;
          end
          default: begin
            if (r_cnt == LAST) begin
              // Result registers hold until the next completed frame.
              r_sum    <= w_final;
              r_sample <= w_sample;
              r_sat    <= w_sat;
              r_valid  <= 1'b1;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= ST_IDLE;
            end else begin
              r_acc <= w_final;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign o_busy   = (r_state == ST_ACCUM);
  assign o_valid  = r_valid;
  assign o_sum    = r_sum;
  assign o_sample = r_sample;
  assign o_sat    = r_sat;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised and directed bench for product_accumulator against a frame-level sum model.
module tb_product_accumulator;

  localparam int TAPS  = 8;
  localparam int SHIFT = 7;
  localparam int OUT_W = 8;
  localparam int ACC_W = 19;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    clear = 1'b0;
  logic                    valid = 1'b0;
  logic signed [15:0]      product = '0;
  logic                    busy;
  logic                    out_valid;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] sample;
  logic                    sat;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: list of products in the open frame, plus last result.
  longint frame_q[$];
  longint exp_sum = 0;
  longint exp_sample = 0;
  longint exp_sat = 0;
  longint exp_valid = 0;
  int     n_pulses = 0;

  product_accumulator #(
    .TAPS  (TAPS),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clear   (clear),
    .i_valid   (valid),
    .i_product (product),
    .o_busy    (busy),
    .o_valid   (out_valid),
    .o_sum     (sum),
    .o_sample  (sample),
    .o_sat     (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_result(input longint total);
    longint r;
    r = floor_div(total + (64'sd1 << (SHIFT - 1)), 64'sd1 << SHIFT);
    exp_sum = total;
    if (r > 127) begin
      exp_sample = 127;
      exp_sat = 1;
    end else if (r < -128) begin
      exp_sample = -128;
      exp_sat = 1;
    end else begin
      exp_sample = r;
      exp_sat = 0;
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    exp_sum = 0;
    exp_sample = 0;
    exp_sat = 0;
    exp_valid = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".valid"}, longint'(out_valid), exp_valid);
    check({ctx, ".busy"}, longint'(busy), longint'(frame_q.size() != 0));
    check({ctx, ".sum"}, longint'(sum), exp_sum);
    check({ctx, ".sample"}, longint'(sample), exp_sample);
    check({ctx, ".sat"}, longint'(sat), exp_sat);
  endtask

  // One clock: drive on the falling edge, update the model, check 1 ns after the rising edge.
  task automatic drive(input bit v, input bit c, input int p, input string ctx);
    longint total;
    @(negedge clk);
    valid   = v;
    clear   = c;
    product = 16'(p);
    exp_valid = 0;
    if (c) begin
      frame_q.delete();
    end else if (v) begin
      frame_q.push_back(longint'(p));
      if (frame_q.size() == TAPS) begin
        total = 0;
        foreach (frame_q[i]) total += frame_q[i];
        model_result(total);
        exp_valid = 1;
        frame_q.delete();
      end
    end
    @(posedge clk);
    #1;
    if (out_valid) n_pulses++;
    check_outputs(ctx);
  endtask

  task automatic idle(input int n, input string ctx);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, ctx);
  endtask

  initial begin
    int pick;
    int p;

    // Reset held with active-looking inputs.
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid   = 1'b1;
      product = (i % 2 == 0) ? 16'sd100 : 16'sd0;
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
    end
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;

    // Nominal frame.
    for (int i = 0; i < TAPS; i++) drive(1'b1, 1'b0, 100, "nominal");
    check("nominal_sum", longint'(sum), 800);
    check("nominal_sample", longint'(sample), 6);
    idle(1, "nominal_tail");

    // Positive and negative saturation.
    for (int i = 0; i < TAPS; i++) drive(1'b1, 1'b0, 16384, "pos_sat");
    check("pos_sat_sum", longint'(sum), 131072);
    check("pos_sat_sample", longint'(sample), 127);
    check("pos_sat_flag", longint'(sat), 1);
    for (int i = 0; i < TAPS; i++) drive(1'b1, 1'b0, -16256, "neg_sat");
    check("neg_sat_sum", longint'(sum), -130048);
    check("neg_sat_sample", longint'(sample), -128);
    idle(2, "neg_sat_tail");

    // Reset in the middle of a frame: partial sum and held results are discarded.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 100, "pre_rst");
    @(negedge clk);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    n_pulses = 0;
    for (int i = 0; i < TAPS; i++) drive(1'b1, 1'b0, 100, "post_rst");
    check("post_rst_sum", longint'(sum), 800);
    check("post_rst_pulses", longint'(n_pulses), 1);
    idle(1, "post_rst_tail");

    // Gaps and clear.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 7, "gap_a");
    idle(3, "gap_idle");
    drive(1'b1, 1'b1, 500, "clear");
    for (int i = 0; i < TAPS; i++) drive(1'b1, 1'b0, 1, "after_clear");
    check("after_clear_sum", longint'(sum), 8);
    check("after_clear_sample", longint'(sample), 0);
    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, 10 * i, "gap_b");
    idle(4, "gap_b_idle");
    for (int i = 4; i <= 8; i++) drive(1'b1, 1'b0, 10 * i, "gap_c");
    check("gap_sum", longint'(sum), 360);
    check("gap_sample", longint'(sample), 3);

    // Back-to-back frames with no bubble.
    n_pulses = 0;
    for (int i = 0; i < 2 * TAPS; i++) drive(1'b1, 1'b0, (i < TAPS) ? 100 : -100, "b2b");
    check("b2b_sum", longint'(sum), -800);
    check("b2b_sample", longint'(sample), -6);
    check("b2b_pulses", longint'(n_pulses), 2);

    // Randomised traffic including extremes, gaps and occasional clears.
    for (int i = 0; i < 600; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0:       p = 16384;
        1:       p = -16256;
        2:       p = -32768;
        3:       p = 32767;
        4:       p = $urandom_range(0, 400) - 200;
        default: p = int'($signed(16'($urandom)));
      endcase
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, p, "rand");
    end
    idle(2, "final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 8x8 signed multiplier. Accumulates a frame of TAPS signed 16-bit products, which makes it the summation half of an FIR/MAC datapath.
- At frame end it emits the full-precision sum and a rounded, shifted, saturated 8-bit output sample.
- Handshake is valid-only. Input gaps are allowed and frames may run back-to-back.

Parameters:
- TAPS, 8, products per frame; legal range 2..256.
- SHIFT, 7, arithmetic right shift applied to the sum to form the output sample; legal range 1..ACC_W-1.
- OUT_W, 8, width of the signed output sample.
- ACC_W, 16+clog2(TAPS) (19 for default), signed accumulator width. Overflow is impossible by construction.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Clear  in  1  synchronous frame abort/restart.
- InValid  in  1  InProduct is valid this cycle; always accepted, no backpressure.
- InProduct  in  16  signed product from the multiplier.
- Busy  out  1  high while a partial frame is held (state ACCUM).
- OutValid  out  1  one-cycle pulse: frame result valid.
- OutSum  out  ACC_W  signed full-precision frame sum.
- OutSample  out  OUT_W  signed rounded/saturated sample.
- OutSat  out  1  OutSample was clipped this frame.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - acc=0, count=0, state=IDLE.
  - Busy=0, OutValid=0, OutSum=0, OutSample=0, OutSat=0.
  - Reset mid-frame discards the partial sum; no OutValid is produced for that frame.
- States:
  - IDLE: no partial sum held.
  - ACCUM: count products accepted, 1 <= count <= TAPS-1.
- Accept rule: a product is accepted on every rising edge with InValid=1 and Clear=0. With InValid=0, acc, count and state hold.
- IDLE + accept: acc <= sext(InProduct), count <= 1, go to ACCUM.
- ACCUM + accept with count < TAPS-1: acc <= acc + sext(InProduct), count <= count+1.
- ACCUM + accept with count = TAPS-1 (final product), all on the same edge:
  - final = acc + sext(InProduct);
  - OutSum <= final, OutSample/OutSat <= round_sat(final), OutValid <= 1;
  - acc <= 0, count <= 0, go to IDLE.
- Latency: OutValid rises on the edge after the TAPS-th accepted product and stays high exactly one cycle.
- Back-to-back frames: a product arriving in the cycle OutValid is high is accepted as product 1 of the next frame (IDLE path). No bubble, no loss.
- Output holding: OutSum, OutSample and OutSat hold their values until the next frame completes. They are not cleared when OutValid drops.
- Clear=1:
  - acc <= 0, count <= 0, go to IDLE.
  - Any InProduct in the same cycle is dropped.
  - OutValid <= 0, even if that cycle would have completed the frame.
  - Previous OutSum/OutSample are retained.
- Clear has priority over InValid; Rst_n has priority over everything.
- round_sat(x):
  - r = (x + 2^(SHIFT-1)) >>> SHIFT, evaluated in ACC_W+1 bits so the rounding add cannot wrap. Round half up: ties round toward +inf.
  - If r > 2^(OUT_W-1)-1, OutSample = 2^(OUT_W-1)-1 (127) and OutSat=1.
  - If r < -2^(OUT_W-1), OutSample = -2^(OUT_W-1) (-128) and OutSat=1.
  - Otherwise OutSample = r[OUT_W-1:0] and OutSat=0.
- Busy = (state == ACCUM), registered.

Decomposition:
- Shared package dsp_pkg:
  - clog2 function;
  - ACC_W derivation;
  - state encoding localparams ST_IDLE=1'b0, ST_ACCUM=1'b1;
  - default OUT_W=8, reused by the multiplier and downstream stages.
- One combinational sub-module, round_saturate, with parameters IN_W, SHIFT and OUT_W, inputs x and outputs y and sat. It is reusable by later scaling stages.
- Counter, accumulator and FSM stay in product_accumulator.

Test Plan:
- Reset: hold Rst_n=0 with InValid=1 and InProduct=100 toggling -> all outputs 0, Busy=0. Assert Rst_n=0 after 3 products, release, then feed 8x100 -> single OutValid, OutSum=800.
- Nominal frame (TAPS=8, SHIFT=7): 8 consecutive products of 100 -> OutValid one cycle after product 8, OutSum=800, OutSample=6 ((800+64)>>>7), OutSat=0. Busy high from product 1 through product 8.
- Positive saturation: 8x16384 (-128*-128) -> OutSum=131072, OutSample=127, OutSat=1.
- Negative saturation: 8x(-16256) (-128*127) -> OutSum=-130048, OutSample=-128, OutSat=1.
- Gaps and Clear:
  - Feed 5 products of 7, InValid=0 for 3 cycles, then Clear=1 with InValid=1 and InProduct=500 -> no OutValid, the 500 is dropped.
  - Then 8x1 -> OutSum=8, OutSample=0.
  - Then products 10,20,30 (OutValid stays low), 4 idle cycles, products 40..80 -> OutSum=360, OutSample=3.
- Back-to-back: 16 consecutive valid products, first 8 = 100, next 8 = -100 -> OutValid high on cycles 9 and 17 after the first accept, OutSum=800 then -800, OutSample=6 then -6. Neither pulse is lost.
